// File: rtl/tft_pixel_source.sv
// rtl/tft_pixel_source.sv - raster-order RGB565 pixel fetcher feeding the TFT SPI display controller
// Build macro TFT_PIXEL_SOURCE_TEST_PATTERN_EN adds a test_mode input selecting 8 vertical colour bars.
module tft_pixel_source #(
    parameter int H_RES  = 240,
    parameter int V_RES  = 320,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_clk,
    input  logic              sof_req,
`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [15:0]       pixel_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rd_data,
    output logic [8:0]        pixel_x,
    output logic [8:0]        pixel_y,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [8:0]        X_LAST    = 9'(H_RES - 1);

    // ST_IDLE exists only for the cycle after reset so the preload fetch starts one cycle later.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic                pclk_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          x_q, x_d;
    logic [8:0]          y_q, y_d;
    logic [15:0]         pixel_q, pixel_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic                underrun_q, underrun_d;
    logic                fall;
    logic                pattern_sel;
    logic [15:0]         fetched;

`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
    function automatic logic [15:0] bar_colour(input logic [8:0] x);
        logic [31:0] idx;
        idx = (32'(x) * 32'd8) / 32'(H_RES);
        case (idx)
            32'd0:   return 16'hFFFF;
            32'd1:   return 16'hFFE0;
            32'd2:   return 16'h07FF;
            32'd3:   return 16'h07E0;
            32'd4:   return 16'hF81F;
            32'd5:   return 16'hF800;
            32'd6:   return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    assign pattern_sel = test_mode;
    assign fetched     = test_mode ? bar_colour(x_q) : mem_rd_data;
`else
    assign pattern_sel = 1'b0;
    assign fetched     = mem_rd_data;
`endif

    assign fall = pclk_q & ~pixel_clk;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        x_d           = x_q;
        y_d           = y_q;
        pixel_d       = pixel_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        underrun_d    = underrun_q;

        // A restart overrides everything, including a coincident edge and any fetch in flight.
        if (sof_req) begin
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    if (fall) underrun_d = 1'b1;
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
                    if (fall) underrun_d = 1'b1;
                end
                ST_WAIT: begin
                    pixel_d = fetched;
                    state_d = ST_READY;
                    if (fall) underrun_d = 1'b1;
                end
                ST_READY: begin
                    if (fall) begin
                        state_d = ST_FETCH;
                        if (addr_q == LAST_ADDR) begin
                            addr_d        = '0;
                            x_d           = '0;
                            y_d           = '0;
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + 8'd1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + 9'd1;
                            end else begin
                                x_d = x_q + 9'd1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pclk_q        <= 1'b0;
            addr_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pixel_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pclk_q        <= pixel_clk;
            addr_q        <= addr_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pixel_q       <= pixel_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            underrun_q    <= underrun_d;
        end
    end

    assign mem_rd_en   = (state_q == ST_FETCH) & ~pattern_sel;
    assign mem_addr    = addr_q;
    assign pixel_data  = pixel_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_tft_pixel_source.sv
// tb/tb_tft_pixel_source.sv - randomized directed bench for tft_pixel_source against a raster-index model
// Uses a short 240x3 frame; define TFT_PIXEL_SOURCE_TEST_PATTERN_EN to also exercise the colour bars.
module tb_tft_pixel_source;

    localparam int H    = 240;
    localparam int V    = 3;
    localparam int AW   = 17;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          pixel_clk;
    logic          sof_req;
    logic [15:0]   pixel_data;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [15:0]   mem_rd_data;
    logic [8:0]    pixel_x;
    logic [8:0]    pixel_y;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          underrun;
`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
    logic          test_mode;
`endif

    logic [15:0] mem [0:NPIX-1];
    logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int vectors = 0;
    int errors  = 0;
    int p;
    int fc;
    logic ur;
    bit tm;

    tft_pixel_source #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_clk   (pixel_clk),
        .sof_req     (sof_req),
`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .pixel_data  (pixel_data),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[int'(mem_addr)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pixel();
        if (tm) return bars[((p % H) * 8) / H];
        return mem[p];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (tm) chk("rd_en_in_test_mode", 32'(mem_rd_en), 32'd0);
    endtask

    task automatic check_pos(input string tag);
        chk({tag, "_x"},       32'(pixel_x),     32'(p % H));
        chk({tag, "_y"},       32'(pixel_y),     32'(p / H));
        chk({tag, "_addr"},    32'(mem_addr),    32'(p));
        chk({tag, "_pixel"},   32'(pixel_data),  32'(exp_pixel()));
        chk({tag, "_frames"},  32'(frame_count), 32'(fc));
        chk({tag, "_underrun"}, 32'(underrun),   32'(ur));
    endtask

    // One consumer advance from READY; checks frame_done timing, the 3-cycle latency and the new position.
    task automatic advance(input int extra);
        logic [15:0] prev;
        bit last;
        prev = exp_pixel();
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        last = (p == NPIX - 1);
        if (last) begin
            p  = 0;
            fc = (fc + 1) % 256;
        end else begin
            p++;
        end
        tick();
        chk("frame_done", 32'(frame_done), 32'(last));
        tick();
        chk("latency_hold", 32'(pixel_data), 32'(prev));
        chk("frame_done_single", 32'(frame_done), 32'd0);
        tick();
        check_pos("adv");
        repeat (extra) tick();
    endtask

    initial begin
        rst       = 1'b1;
        pixel_clk = 1'b0;
        sof_req   = 1'b0;
        tm        = 1'b0;
`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
        mem[0] = 16'd1234;
        p  = 0;
        fc = 0;
        ur = 1'b0;

        // Reset values, then the preload fetch of pixel 0.
        repeat (3) tick();
        chk("rst_pixel",  32'(pixel_data),  32'd0);
        chk("rst_rd_en",  32'(mem_rd_en),   32'd0);
        chk("rst_addr",   32'(mem_addr),    32'd0);
        chk("rst_x",      32'(pixel_x),     32'd0);
        chk("rst_y",      32'(pixel_y),     32'd0);
        chk("rst_fdone",  32'(frame_done),  32'd0);
        chk("rst_fcount", 32'(frame_count), 32'd0);
        chk("rst_urun",   32'(underrun),    32'd0);
        rst = 1'b0;
        tick();
        chk("pre_rd_en_c1", 32'(mem_rd_en), 32'd1);
        chk("pre_addr_c1",  32'(mem_addr),  32'd0);
        tick();
        chk("pre_rd_en_c2", 32'(mem_rd_en), 32'd0);
        tick();
        chk("pre_pixel_c3", 32'(pixel_data), 32'd1234);
        check_pos("preload");

        // Widely spaced advances, then a full frame at random spacing.
        for (int i = 0; i < 8; i++) advance(16);
        for (int i = 8; i < NPIX; i++) advance(int'($urandom_range(0, 12)));
        check_pos("frame_end");

        // Move to pixel 500 and restart there.
        for (int i = 0; i < 500; i++) advance(int'($urandom_range(0, 3)));
        sof_req = 1'b1;
        tick();
        sof_req = 1'b0;
        p = 0;
        tick();
        tick();
        check_pos("sof_at_500");

        // Restart while a fetch is in flight (FETCH, then WAIT): its data must never load.
        for (int d = 0; d < 2; d++) begin
            logic [15:0] prev;
            repeat (3) advance(1);
            prev = exp_pixel();
            pixel_clk = 1'b1;
            tick();
            pixel_clk = 1'b0;
            tick();
            repeat (d) tick();
            sof_req = 1'b1;
            tick();
            sof_req = 1'b0;
            p = 0;
            chk("sof_discard_hold", 32'(pixel_data), 32'(prev));
            tick();
            tick();
            check_pos("sof_discard");
        end

        // Restart coincident with an edge, in READY and then in FETCH.
        repeat (5) advance(0);
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        sof_req   = 1'b1;
        tick();
        sof_req = 1'b0;
        p = 0;
        tick();
        tick();
        check_pos("sof_fall_ready");
        repeat (4) advance(0);
        sof_req   = 1'b1;
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        tick();
        sof_req = 1'b0;
        p = 0;
        tick();
        tick();
        check_pos("sof_fall_fetch");

        // Two edges two cycles apart: one advance, underrun latches.
        repeat (3) advance(int'($urandom_range(0, 4)));
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        tick();
        p++;
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        tick();
        ur = 1'b1;
        check_pos("underrun");
        repeat (6) advance(int'($urandom_range(0, 4)));

        // Reset while a fetch is in flight.
        pixel_clk = 1'b1;
        tick();
        pixel_clk = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_pixel",  32'(pixel_data),  32'd0);
        chk("midrst_urun",   32'(underrun),    32'd0);
        chk("midrst_fcount", 32'(frame_count), 32'd0);
        chk("midrst_x",      32'(pixel_x),     32'd0);
        chk("midrst_rd_en",  32'(mem_rd_en),   32'd0);
        rst = 1'b0;
        p  = 0;
        fc = 0;
        ur = 1'b0;
        tick();
        tick();
        tick();
        check_pos("midrst_reload");

`ifdef TFT_PIXEL_SOURCE_TEST_PATTERN_EN
        test_mode = 1'b1;
        tm        = 1'b1;
        sof_req   = 1'b1;
        tick();
        sof_req = 1'b0;
        p = 0;
        tick();
        tick();
        check_pos("bar_x0");
        for (int i = 0; i < 30; i++) advance(int'($urandom_range(0, 2)));
        chk("bar_x30", 32'(pixel_data), 32'h0000FFE0);
        for (int i = 30; i < 239; i++) advance(int'($urandom_range(0, 2)));
        chk("bar_x239", 32'(pixel_data), 32'h00000000);
        test_mode = 1'b0;
        tm        = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tft_pixel_source.md
Name: tft_pixel_source

Overview:
- Upstream pixel feeder for the TFT SPI display controller.
- Scans a pixel memory in raster order and presents one RGB565 pixel on pixel_data.
- Advances one pixel per falling edge of the controller's framebuffer strobe, which it receives on pixel_clk.
- Owns the memory read port, the x/y position, frame accounting and underrun detection.

Parameters:
- H_RES, 240, pixels per line.
- V_RES, 320, lines per frame.
- ADDR_W, 17, memory address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  in  1  system clock; same clock as the display controller.
- rst  in  1  synchronous, active-high reset.
- pixel_clk  in  1  framebuffer strobe from the display controller. Falling edge means both bytes of the current pixel have been consumed.
- sof_req  in  1  single-cycle pulse; restarts the scan at pixel 0.
- pixel_data  out  16  current RGB565 pixel.
- mem_addr  out  ADDR_W  pixel memory read address.
- mem_rd_en  out  1  read strobe; memory returns mem_rd_data exactly 1 cycle after a cycle with mem_rd_en=1.
- mem_rd_data  in  16  read data.
- pixel_x  out  9  column of the pixel on pixel_data.
- pixel_y  out  9  row of the pixel on pixel_data.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is consumed.
- frame_count  out  8  completed frames; wraps 255->0.
- underrun  out  1  sticky flag: an advance arrived while a fetch was still in flight.

Behaviour:
- Edge detect: pixel_clk is registered once (pclk_q). fall = pclk_q & ~pixel_clk. pclk_q resets to 0, so no spurious edge after reset.
- States:
  - FETCH: drive mem_addr, mem_rd_en=1 for exactly one cycle, go to WAIT.
  - WAIT: next cycle, load pixel_data <= mem_rd_data, go to READY.
  - READY: hold pixel_data, mem_rd_en=0.
- Advance latency: fall seen in cycle N -> FETCH in N+1 -> pixel_data valid from N+3.
  - Consumer needs >= 9 SPI bit times between bytes, so 3 cycles is within margin.
- Fall in READY:
  - addr <= addr+1; pixel_x+1.
  - At pixel_x==H_RES-1: pixel_x=0, pixel_y+1.
  - At last pixel (addr==H_RES*V_RES-1): addr, x and y all go to 0; frame_done pulses in the same cycle; frame_count increments modulo 256.
  - Then go to FETCH.
- Fall in FETCH or WAIT:
  - underrun <= 1; the edge is dropped.
  - Position unchanged; the fetch in flight completes normally.
- sof_req, any state:
  - addr, x and y go to 0; go to FETCH next cycle.
  - Any fetch in flight is discarded: its data is not loaded.
  - frame_count and underrun are unchanged; frame_done is not pulsed.
- sof_req and fall in the same cycle: sof_req wins; the fall is ignored and does not set underrun.
- Reset values:
  - pixel_data=0, mem_addr=0, mem_rd_en=0, pixel_x=0, pixel_y=0, frame_done=0, frame_count=0, underrun=0.
  - State goes to FETCH in the first cycle after rst deasserts, so pixel 0 is preloaded before the first advance.
- Reset mid-fetch: all state returns to reset values immediately; the pending read data is ignored.
- Arithmetic:
  - addr is compared against the constant H_RES*V_RES-1, computed at ADDR_W width.
  - pixel_x and pixel_y are 9-bit, so H_RES and V_RES must be <= 512.
  - mem_addr always equals addr, registered.

Optional Feature:
- Macro: TFT_PIXEL_SOURCE_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - While test_mode=1, pixel_data comes from 8 vertical colour bars on pixel_x. Bar index = pixel_x*8/H_RES; colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - mem_rd_en stays 0 in this mode.
  - Timing and counters are identical to memory mode, including the 3-cycle latency and underrun detection.
- Undefined:
  - No test_mode port; pixel_data always comes from memory.

Test Plan:
- Reset release with mem[0]=1234 -> mem_rd_en high in cycle 1 with mem_addr=0; pixel_data=1234 by cycle 3; underrun=0.
- Falls spaced 20 cycles apart, mem[i]=i -> pixel_data steps 0,1,2,... each valid 3 cycles after its fall; pixel_x wraps 239->0 with pixel_y incrementing.
- 76800 falls (240x320) -> exactly one frame_done pulse on the last fall; frame_count=1; pixel_x=pixel_y=mem_addr=0; pixel_data=mem[0].
- Two falls 2 cycles apart -> underrun=1 and stays set; position advances by only 1.
- sof_req pulsed at pixel 500, plus sof_req coincident with a fall -> position returns to 0 and pixel_data=mem[0]; frame_count unchanged; no underrun from the coincident fall.
- With TFT_PIXEL_SOURCE_TEST_PATTERN_EN and test_mode=1 -> pixel_x=0 gives FFFF, pixel_x=30 gives FFE0, pixel_x=239 gives 0000; mem_rd_en stays 0.
